// File: rtl/alu_pkg.sv
// Shared constants and the decoded-beat record for the RV64I ALU issue stage.
package alu_pkg;

   localparam int ALU_XLEN = 64;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [1:0] {
      SK_EMPTY = 2'b00,
      SK_ONE   = 2'b01,
      SK_FULL  = 2'b10
   } skid_state_t;

   typedef struct packed {
      logic [3:0]          alu_op;
      logic [ALU_XLEN-1:0] op_a;
      logic [ALU_XLEN-1:0] op_b;
      logic [4:0]          rd;
      logic                we;
      logic                br;
      logic                br_inv;
      logic                illegal;
   } issue_t;

   function automatic logic [ALU_XLEN-1:0] sext12(input logic [11:0] imm);
      return {{(ALU_XLEN-12){imm[11]}}, imm};
   endfunction

endpackage

// File: rtl/alu_issue_skid.sv
// Valid/ready register stage carrying decoded ALU beats.
// ALU_ISSUE_SKID_EN selects a 2-entry skid buffer with registered in_ready.
module alu_issue_skid
   import alu_pkg::*;
#(
   parameter int W = $bits(issue_t)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

`ifdef ALU_ISSUE_SKID_EN
   skid_state_t  state_q, state_d;
   logic [W-1:0] head_q, head_d;
   logic [W-1:0] tail_q, tail_d;
   logic         in_ready_q, in_ready_d;
   logic         push_s, pop_s;

   // Occupancy FSM: head is always the presented beat, tail the absorbed one.
   always_comb begin
      push_s     = in_valid && in_ready_q && !flush;
      pop_s      = (state_q != SK_EMPTY) && out_ready;
      state_d    = state_q;
      head_d     = head_q;
      tail_d     = tail_q;
      if (flush) begin
         state_d = SK_EMPTY;
      end else begin
         case (state_q)
            SK_EMPTY: begin
               if (push_s) begin
                  head_d  = in_data;
                  state_d = SK_ONE;
               end else begin
                  state_d = SK_EMPTY;
               end
            end
            SK_ONE: begin
               if (push_s && pop_s) begin
                  head_d = in_data;
               end else if (push_s) begin
                  tail_d  = in_data;
                  state_d = SK_FULL;
               end else if (pop_s) begin
                  state_d = SK_EMPTY;
               end else begin
                  state_d = SK_ONE;
               end
            end
            SK_FULL: begin
               if (pop_s) begin
                  head_d  = tail_q;
                  state_d = SK_ONE;
               end else begin
                  state_d = SK_FULL;
               end
            end
            default: state_d = SK_EMPTY;
         endcase
      end
      in_ready_d = (state_d != SK_FULL);
   end

   // State and storage registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= SK_EMPTY;
         head_q     <= '0;
         tail_q     <= '0;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != SK_EMPTY);
   assign out_data  = head_q;
`else
   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;
   logic         push_s;

   assign in_ready = !valid_q || out_ready;

   // Single holding register; refills in the same cycle it drains.
   always_comb begin
      push_s  = in_valid && in_ready && !flush;
      valid_d = valid_q;
      data_d  = data_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (push_s) begin
         valid_d = 1'b1;
         data_d  = in_data;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // Holding register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
`endif

endmodule

// File: rtl/alu_issue.sv
// RV64I execute-stage issue: decodes a register-read beat into ALU op/operands.
// Define ALU_ISSUE_SKID_EN for a 2-entry skid buffer with registered in_ready.
module alu_issue
   import alu_pkg::*;
#(
   parameter int XLEN = ALU_XLEN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [3:0]      alu_op,
   output logic [XLEN-1:0] op_a,
   output logic [XLEN-1:0] op_b,
   output logic [4:0]      rd,
   output logic            we,
   output logic            br,
   output logic            br_inv,
   output logic            illegal
);

   logic [6:0]      opcode_s;
   logic [2:0]      funct3_s;
   logic [6:0]      funct7_s;
   logic [3:0]      alu_op_s;
   logic [XLEN-1:0] op_b_s;
   logic            we_s;
   logic            br_s;
   logic            br_inv_s;
   logic            legal_s;
   logic            unused_rs1_field;
   issue_t          dec_s;
   issue_t          head_s;

   assign opcode_s         = instr[6:0];
   assign funct3_s         = instr[14:12];
   assign funct7_s         = instr[31:25];
   assign unused_rs1_field = ^instr[19:15];

   // Opcode/funct decode into ALU control; legality resolved alongside.
   always_comb begin
      alu_op_s = ALU_ADD;
      op_b_s   = rs2_val;
      we_s     = 1'b0;
      br_s     = 1'b0;
      br_inv_s = 1'b0;
      legal_s  = 1'b0;
      case (opcode_s)
         OPC_OP: begin
            we_s = 1'b1;
            if (funct7_s == F7_ALT) begin
               alu_op_s = ALU_SUB;
               legal_s  = (funct3_s == F3_ADD);
            end else if (funct7_s == F7_BASE) begin
               legal_s = 1'b1;
               case (funct3_s)
                  F3_ADD:  alu_op_s = ALU_ADD;
                  F3_OR:   alu_op_s = ALU_OR;
                  F3_AND:  alu_op_s = ALU_AND;
                  F3_SLTU: alu_op_s = ALU_SLT;
                  default: legal_s  = 1'b0;
               endcase
            end else begin
               legal_s = 1'b0;
            end
         end
         OPC_OPIMM: begin
            we_s    = 1'b1;
            op_b_s  = sext12(instr[31:20]);
            legal_s = 1'b1;
            case (funct3_s)
               F3_ADD:  alu_op_s = ALU_ADD;
               F3_OR:   alu_op_s = ALU_OR;
               F3_AND:  alu_op_s = ALU_AND;
               F3_SLTU: alu_op_s = ALU_SLT;
               default: legal_s  = 1'b0;
            endcase
         end
         OPC_LOAD: begin
            we_s    = 1'b1;
            op_b_s  = sext12(instr[31:20]);
            legal_s = 1'b1;
         end
         OPC_STORE: begin
            op_b_s  = sext12({instr[31:25], instr[11:7]});
            legal_s = 1'b1;
         end
         OPC_BRANCH: begin
            br_s    = 1'b1;
            legal_s = 1'b1;
            case (funct3_s)
               F3_BEQ: begin
                  alu_op_s = ALU_SUB;
                  br_inv_s = 1'b0;
               end
               F3_BNE: begin
                  alu_op_s = ALU_SUB;
                  br_inv_s = 1'b1;
               end
               F3_BLTU: begin
                  alu_op_s = ALU_SLT;
                  br_inv_s = 1'b1;
               end
               F3_BGEU: begin
                  alu_op_s = ALU_SLT;
                  br_inv_s = 1'b0;
               end
               default: legal_s = 1'b0;
            endcase
         end
         default: legal_s = 1'b0;
      endcase
   end

   // Unsupported encodings still travel downstream, as a harmless ADD with no side effects.
   assign dec_s = legal_s ?
      '{alu_op: alu_op_s, op_a: rs1_val, op_b: op_b_s, rd: instr[11:7],
        we: we_s, br: br_s, br_inv: br_inv_s, illegal: 1'b0} :
      '{alu_op: ALU_ADD, op_a: rs1_val, op_b: rs2_val, rd: instr[11:7],
        we: 1'b0, br: 1'b0, br_inv: 1'b0, illegal: 1'b1};

   alu_issue_skid #(
      .W($bits(issue_t))
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (dec_s),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (head_s)
   );

   assign alu_op  = head_s.alu_op;
   assign op_a    = head_s.op_a;
   assign op_b    = head_s.op_b;
   assign rd      = head_s.rd;
   assign we      = head_s.we;
   assign br      = head_s.br;
   assign br_inv  = head_s.br_inv;
   assign illegal = head_s.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: queue model of the handshake plus a
// pattern-table decoder, compared on every falling edge.
module tb_alu_issue;

`ifdef ALU_ISSUE_SKID_EN
   localparam bit SKID_MODE = 1'b1;
`else
   localparam bit SKID_MODE = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic [63:0] rs1_val;
   logic [63:0] rs2_val;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  alu_op;
   logic [63:0] op_a;
   logic [63:0] op_b;
   logic [4:0]  rd;
   logic        we;
   logic        br;
   logic        br_inv;
   logic        illegal;

   alu_issue dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .rs1_val(rs1_val), .rs2_val(rs2_val),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_op(alu_op), .op_a(op_a), .op_b(op_b), .rd(rd),
      .we(we), .br(br), .br_inv(br_inv), .illegal(illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [4:0]  rd;
      logic        we;
      logic        br;
      logic        inv;
      logic        ill;
   } exp_t;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                               input logic [4:0] r, input logic w, input logic bb,
                               input logic inv, input logic ill);
      exp_t e;
      e.op = op; e.a = a; e.b = b; e.rd = r; e.we = w; e.br = bb; e.inv = inv; e.ill = ill;
      return e;
   endfunction

   // Reference decoder: whole-word patterns straight from the supported-instruction list.
   function automatic exp_t ref_beat(input logic [31:0] i, input logic [63:0] a, input logic [63:0] b);
      logic [63:0] immi;
      logic [63:0] imms;
      exp_t        e;
      immi = {{52{i[31]}}, i[31:20]};
      imms = {{52{i[31]}}, i[31:25], i[11:7]};
      casez (i)
         32'b0000000_?????_?????_000_?????_0110011: e = mk(4'b0010, a, b, i[11:7], 1'b1, 1'b0, 1'b0, 1'b0);
         32'b0000000_?????_?????_110_?????_0110011: e = mk(4'b0001, a, b, i[11:7], 1'b1, 1'b0, 1'b0, 1'b0);
         32'b0000000_?????_?????_111_?????_0110011: e = mk(4'b0000, a, b, i[11:7], 1'b1, 1'b0, 1'b0, 1'b0);
         32'b0000000_?????_?????_011_?????_0110011: e = mk(4'b0111, a, b, i[11:7], 1'b1, 1'b0, 1'b0, 1'b0);
         32'b0100000_?????_?????_000_?????_0110011: e = mk(4'b0110, a, b, i[11:7], 1'b1, 1'b0, 1'b0, 1'b0);
         32'b????????????_?????_000_?????_0010011:  e = mk(4'b0010, a, immi, i[11:7], 1'b1, 1'b0, 1'b0, 1'b0);
         32'b????????????_?????_110_?????_0010011:  e = mk(4'b0001, a, immi, i[11:7], 1'b1, 1'b0, 1'b0, 1'b0);
         32'b????????????_?????_111_?????_0010011:  e = mk(4'b0000, a, immi, i[11:7], 1'b1, 1'b0, 1'b0, 1'b0);
         32'b????????????_?????_011_?????_0010011:  e = mk(4'b0111, a, immi, i[11:7], 1'b1, 1'b0, 1'b0, 1'b0);
         32'b????????????_?????_???_?????_0000011:  e = mk(4'b0010, a, immi, i[11:7], 1'b1, 1'b0, 1'b0, 1'b0);
         32'b???????_?????_?????_???_?????_0100011: e = mk(4'b0010, a, imms, i[11:7], 1'b0, 1'b0, 1'b0, 1'b0);
         32'b???????_?????_?????_000_?????_1100011: e = mk(4'b0110, a, b, i[11:7], 1'b0, 1'b1, 1'b0, 1'b0);
         32'b???????_?????_?????_001_?????_1100011: e = mk(4'b0110, a, b, i[11:7], 1'b0, 1'b1, 1'b1, 1'b0);
         32'b???????_?????_?????_110_?????_1100011: e = mk(4'b0111, a, b, i[11:7], 1'b0, 1'b1, 1'b1, 1'b0);
         32'b???????_?????_?????_111_?????_1100011: e = mk(4'b0111, a, b, i[11:7], 1'b0, 1'b1, 1'b0, 1'b0);
         default:                                   e = mk(4'b0010, a, b, i[11:7], 1'b0, 1'b0, 1'b0, 1'b1);
      endcase
      return e;
   endfunction

   // Model state: beats owed to the ALU in order, plus the registered-ready view.
   exp_t exp_q[$];
   bit   skid_rdy;
   bit   cur_rdy;
   bit   m_fire;
   bit   m_pop;
   exp_t head_e;

   initial begin : model_cmp
      skid_rdy = 1'b1;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete();
            skid_rdy = 1'b1;
            chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
            chk("rst_payload_or", {63'd0, |{alu_op, op_a, op_b, rd, we, br, br_inv, illegal}}, 64'd0);
         end else begin
            cur_rdy = SKID_MODE ? skid_rdy : ((exp_q.size() == 0) || out_ready);
            chk("in_ready", {63'd0, in_ready}, {63'd0, cur_rdy});
            chk("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
               head_e = exp_q[0];
               chk("alu_op", {60'd0, alu_op}, {60'd0, head_e.op});
               chk("op_a", op_a, head_e.a);
               chk("op_b", op_b, head_e.b);
               chk("rd", {59'd0, rd}, {59'd0, head_e.rd});
               chk("flags", {60'd0, we, br, br_inv, illegal},
                   {60'd0, head_e.we, head_e.br, head_e.inv, head_e.ill});
            end
            m_fire = in_valid && cur_rdy && !flush;
            m_pop  = (exp_q.size() != 0) && out_ready;
            if (flush) begin
               exp_q.delete();
            end else begin
               if (m_pop) void'(exp_q.pop_front());
               if (m_fire) exp_q.push_back(ref_beat(instr, rs1_val, rs2_val));
            end
            skid_rdy = (exp_q.size() < 2);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] i, input logic [63:0] a, input logic [63:0] b, output int cyc);
      bit rdy;
      instr    = i;
      rs1_val  = a;
      rs2_val  = b;
      in_valid = 1'b1;
      cyc      = 0;
      rdy      = 1'b0;
      while (!rdy && cyc < 40) begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("send_accepted", {63'd0, rdy}, 64'd1);
      in_valid = 1'b0;
   endtask

   logic [31:0] vec_i [0:5] = '{32'h40208133, 32'h0020B423, 32'h0020F063,
                                32'h000012B7, 32'hFFF13093, 32'h022081B3};
   exp_t pin;
   int   cyc;
   int   cyc2;
   int   total;

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      instr = 32'd0; rs1_val = 64'd0; rs2_val = 64'd0;

      pin = ref_beat(32'h002081B3, 64'd5, 64'd7);
      chk("pin_add", {pin.op, pin.rd, pin.we, pin.ill}, {4'b0010, 5'd3, 1'b1, 1'b0});
      pin = ref_beat(32'hFFF08093, 64'd10, 64'd0);
      chk("pin_addi_imm", pin.b, 64'hFFFF_FFFF_FFFF_FFFF);
      pin = ref_beat(32'h00209463, 64'd1, 64'd2);
      chk("pin_bne", {pin.op, pin.br, pin.inv, pin.we}, {4'b0110, 1'b1, 1'b1, 1'b0});
      pin = ref_beat(32'h0020A1B3, 64'd1, 64'd2);
      chk("pin_slt_signed", {pin.ill, pin.we, pin.op}, {1'b1, 1'b0, 4'b0010});
      pin = ref_beat(32'h0020B423, 64'd0, 64'd0);
      chk("pin_store_imm", {pin.b, pin.we}, {64'd8, 1'b0});
      pin = ref_beat(32'h0020F063, 64'd0, 64'd0);
      chk("pin_bgeu", {pin.op, pin.inv}, {4'b0111, 1'b0});

      repeat (2) @(negedge clk);
      chk("reset_alu_op", {60'd0, alu_op}, 64'd0);
      chk("reset_op_b", op_b, 64'd0);
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_in_ready", {63'd0, in_ready}, 64'd1);
      step();

      send(32'h002081B3, 64'd5, 64'd7, cyc);
      @(negedge clk);
      chk("tp_add_valid", {63'd0, out_valid}, 64'd1);
      chk("tp_add", {alu_op, op_a[7:0], op_b[7:0], rd, we}, {4'b0010, 8'd5, 8'd7, 5'd3, 1'b1});
      step();
      send(32'hFFF08093, 64'd10, 64'd0, cyc);
      @(negedge clk);
      chk("tp_addi", {alu_op, we}, {4'b0010, 1'b1});
      chk("tp_addi_imm", op_b, 64'hFFFF_FFFF_FFFF_FFFF);
      step();
      send(32'h00209463, 64'd3, 64'd4, cyc);
      @(negedge clk);
      chk("tp_bne", {alu_op, br, br_inv, we}, {4'b0110, 1'b1, 1'b1, 1'b0});
      step();
      send(32'h0020A1B3, 64'd3, 64'd4, cyc);
      @(negedge clk);
      chk("tp_slt_illegal", {out_valid, illegal, we}, {1'b1, 1'b1, 1'b0});
      step();

      total = 0;
      for (int k = 0; k < 6; k++) begin
         send(vec_i[k], 64'h1000 * (k + 1), 64'hFFFF_0000_0000_0000 ^ k, cyc);
         total += cyc;
      end
      chk("stream_cycles", total, 64'd6);
      repeat (2) step();

      fork
         begin
            send(32'h00100093, 64'hA, 64'd0, cyc2);
            send(32'h00200113, 64'hB, 64'd0, cyc2);
            send(32'h00300193, 64'hC, 64'd0, cyc2);
         end
         begin
            out_ready = 1'b0;
            repeat (4) @(negedge clk);
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
            step();
            out_ready = 1'b1;
         end
      join
      repeat (4) step();

      out_ready = 1'b0;
      in_valid  = 1'b1; instr = 32'h00500213; rs1_val = 64'd1;
      step();
      instr = 32'h00600293; rs1_val = 64'd2;
      step();
      instr = 32'h00700313; rs1_val = 64'd3; flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
      step();
      out_ready = 1'b1;
      repeat (3) step();

      out_ready = 1'b0;
      send(32'h008003B3, 64'd9, 64'd9, cyc);
      @(negedge clk);
      chk("mid_pre_valid", {63'd0, out_valid}, 64'd1);
      #1 rst_n = 1'b0;
      #1 chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
      repeat (2) step();
      rst_n = 1'b1;
      out_ready = 1'b1;
      step();
      send(32'h00C0F433, 64'h55, 64'h0F, cyc);
      repeat (3) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_issue.md
# alu_issue

Execute-stage issue block for the RV64I datapath: accepts one decoded-register-read beat per cycle (instruction word plus rs1/rs2 values), translates it into the 4-bit ALU operation code and the two 64-bit ALU operands, and presents them to the ALU over a valid/ready handshake. It is the producing end of the ALU operation interface and sits between register read and the ALU. Branch-condition interpretation of the ALU zero flag (`br_inv`) and illegal-instruction flagging are also generated here.

## Interface
- `XLEN`, 64, operand width
- `clk` in 1, rising-edge clock
- `rst_n` in 1, asynchronous active-low reset
- `flush` in 1, synchronous pipeline kill
- `in_valid` in 1, upstream beat valid
- `in_ready` out 1, block can accept beat
- `instr` in 32, RV64I instruction word
- `rs1_val` in XLEN, rs1 register value
- `rs2_val` in XLEN, rs2 register value
- `out_valid` out 1, ALU beat valid
- `out_ready` in 1, ALU stage accepts beat
- `alu_op` out 4, ALU operation code
- `op_a` out XLEN, ALU in1
- `op_b` out XLEN, ALU in2
- `rd` out 5, destination register
- `we` out 1, writeback enable
- `br` out 1, beat is a conditional branch
- `br_inv` out 1, branch taken = Z XOR `br_inv`
- `illegal` out 1, unsupported encoding

## Operation
- ALU codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111 (unsigned 64-bit compare), NOR 1100.
- Opcode 0110011 (R, funct7 0000000): funct3 000 ADD, 110 OR, 111 AND, 011 SLT; funct7 0100000 with funct3 000 SUB. `op_b`=rs2_val, `we`=1.
- Opcode 0010011 (I): ADDI 000, ORI 110, ANDI 111, SLTIU 011; `op_b`=sext(instr[31:20]), `we`=1.
- Opcode 0000011 load / 0100011 store: ADD, `op_b`=sext I-imm / S-imm ({instr[31:25],instr[11:7]}); `we`=1 load, 0 store.
- Opcode 1100011: BEQ SUB inv 0; BNE SUB inv 1; BLTU SLT inv 1; BGEU SLT inv 0. `op_b`=rs2_val, `br`=1, `we`=0.
- `op_a`=rs1_val always. `rd`=instr[11:7].
- All else (including signed SLT/SLTI/BLT/BGE, funct7 mismatches): `illegal`=1, `alu_op`=0010, `we`=0, `br`=0; beat still forwarded, never dropped.
- Handshake: transfer when valid&&ready; `out_valid` held and payload stable until `out_ready`. Order preserved.
- `flush`=1: all held beats invalidated next edge; beat offered that cycle discarded regardless of `in_ready`.

## Timing
- Reset (async assert): `out_valid`=0, all payload outputs 0, `in_ready`=1 after release; internal occupancy 0.
- Latency: beat accepted at edge N appears on `out_valid` after edge N (1 cycle).
- Throughput: 1 beat/cycle with `out_ready` high.
- Simultaneous accept and drain: both occur; occupancy unchanged.
- Reset mid-stream: held beats lost, `out_valid` falls immediately.

## Configuration
- `ALU_ISSUE_SKID_EN` defined: 2-entry skid buffer; `in_ready` is a register (= !skid_full), no combinational path from `out_ready` to `in_ready`; 2 beats absorbed under stall.
- Undefined: single output register; `in_ready` = !out_valid || out_ready (combinational); 1 beat held under stall.

## Structure
- Package `alu_pkg`: ALU opcode localparams, RV64I opcode/funct3 constants, packed `issue_t` {alu_op, op_a, op_b, rd, we, br, br_inv, illegal}.
- Sub-module `alu_issue_skid`: generic valid/ready register stage over `issue_t`, macro-selected depth; decode is combinational in `alu_issue`.

## Test plan
- `instr`=0x002081B3, rs1=5, rs2=7 -> next cycle `alu_op`=0010, `op_a`=5, `op_b`=7, `rd`=3, `we`=1.
- `instr`=0xFFF08093 -> `alu_op`=0010, `op_b`=0xFFFF_FFFF_FFFF_FFFF, `we`=1.
- `instr`=0x00209463 -> `alu_op`=0110, `br`=1, `br_inv`=1, `we`=0.
- `instr`=0x0020A1B3 (signed SLT) -> `illegal`=1, `we`=0, beat still delivered.
- `out_ready` low 4 cycles, 3 beats offered back-to-back -> SKID_EN: 2 held, `in_ready` 0 after second accept, third accepted after drain, order intact; without: 1 held.
- `flush` with 2 beats held and `in_valid`=1 -> next cycle `out_valid`=0, nothing delivered; `rst_n` low while `out_valid`=1 -> `out_valid`=0 immediately.
